// File: rtl/ours_axi4_r_id_demux.sv
// ---------------------------------------------------------------------------
// ours_axi4_r_id_demux
//
// Single-input, N-output AXI4 R-channel router. Each incoming burst is steered
// to one output port chosen by an ID field in the first beat's payload. The
// route stays locked until the beat carrying rlast. Each output port has its
// own small FIFO, so a stalled port only blocks input when the beat being
// offered actually targets that port and its FIFO is full. Bursts with an
// illegal ID (sel >= N_OUTPUT) are accepted and discarded. Each one raises a
// one-cycle error pulse and increments a saturating counter.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   slave_rvld    incoming R beat valid
//   slave_r       incoming R beat payload (ID field and rlast inside)
//   slave_rrdy    incoming beat ready
//   master_rvld   per-port beat valid (FIFO non-empty)
//   master_r      per-port payload (FIFO head, unmodified input beat)
//   master_rrdy   per-port ready
//   err_id_vld    one-cycle pulse, registered, after an illegal-ID first beat
//   err_cnt       saturating count of illegal-ID bursts
//   clk_en        request to keep the clock running (for an external ICG)
//   dbg_state     FSM state: 0 = IDLE, 1 = BURST, 2 = DROP
//
// Handshake: a beat transfers on a rising clk edge where valid & ready are
// both high. Valid may not depend on ready. Once raised, valid and its payload
// stay stable until the transfer happens. Ready may be raised or lowered at
// any time.
// ---------------------------------------------------------------------------
module ours_axi4_r_id_demux #(
    parameter int N_OUTPUT       = 4,
    parameter int WIDTH          = 64,
    parameter int RLAST_POSITION = 0,
    parameter int ID_LSB         = 1,
    parameter int ID_WIDTH       = 2,
    parameter int BUF_DEPTH      = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             slave_rvld,
    input  logic [WIDTH-1:0]                 slave_r,
    output logic                             slave_rrdy,
    output logic [N_OUTPUT-1:0]              master_rvld,
    output logic [N_OUTPUT-1:0][WIDTH-1:0]   master_r,
    input  logic [N_OUTPUT-1:0]              master_rrdy,
    output logic                             err_id_vld,
    output logic [15:0]                      err_cnt,
    output logic                             clk_en,
    output logic [1:0]                       dbg_state
);

    localparam int NSEL = 2 ** ID_WIDTH;
    localparam int PTRW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW   = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   port_q;

    logic [ID_WIDTH-1:0]   sel;
    logic                  rlast;
    logic                  sel_legal;
    logic [ID_WIDTH-1:0]   tgt;
    logic                  routing;
    logic                  accept;
    logic [N_OUTPUT-1:0]   fifo_full;
    logic [N_OUTPUT-1:0]   fifo_nempty;
    logic [NSEL-1:0]       full_ext;

    assign sel       = slave_r[ID_LSB +: ID_WIDTH];
    assign rlast     = slave_r[RLAST_POSITION];
    assign sel_legal = ({1'b0, sel} < (ID_WIDTH + 1)'(N_OUTPUT));

    // Full flags padded out to every encodable sel value so any sel can index
    // them; the padding entries are never used because sel_legal gates them.
    always_comb begin
        full_ext               = '0;
        full_ext[N_OUTPUT-1:0] = fifo_full;
    end

    // In BURST the locked port wins over whatever sel the beat carries.
    assign tgt     = (state == ST_BURST) ? port_q : sel;
    assign routing = ((state == ST_IDLE) && sel_legal) || (state == ST_BURST);

    // Ready looks only at the full flag, never at this cycle's pop, so there
    // is no combinational path from master_rrdy to slave_rrdy.
    always_comb begin
        slave_rrdy = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE:  slave_rrdy = sel_legal ? ~full_ext[sel] : 1'b1;
                ST_BURST: slave_rrdy = ~full_ext[port_q];
                ST_DROP:  slave_rrdy = 1'b1;
                default:  slave_rrdy = 1'b0;
            endcase
        end
    end

    assign accept = slave_rvld & slave_rrdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            port_q     <= '0;
            err_id_vld <= 1'b0;
            err_cnt    <= '0;
        end else begin
            err_id_vld <= 1'b0;
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        if (sel_legal) begin
                            port_q <= sel;
                            if (!rlast) state <= ST_BURST;
                        end else begin
                            err_id_vld <= 1'b1;
                            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                            if (!rlast) state <= ST_DROP;
                        end
                    end
                    ST_BURST, ST_DROP: begin
                        if (rlast) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign dbg_state = state;
    assign clk_en    = rst | slave_rvld | (state != ST_IDLE) | (|fifo_nempty);

    for (genvar p = 0; p < N_OUTPUT; p++) begin : g_fifo
        // Sized to a power of two so the pointer indexes it exactly; entries
        // at or beyond BUF_DEPTH are never addressed.
        logic [WIDTH-1:0] mem [2**PTRW];
        logic [PTRW-1:0]  wr_ptr;
        logic [PTRW-1:0]  rd_ptr;
        logic [CW-1:0]    cnt;
        logic             push;
        logic             pop;

        assign push           = accept & routing & (tgt == ID_WIDTH'(p));
        assign pop            = master_rvld[p] & master_rrdy[p];
        assign fifo_full[p]   = (cnt == CW'(BUF_DEPTH));
        assign fifo_nempty[p] = (cnt != '0);
        assign master_rvld[p] = ~rst & fifo_nempty[p];
        assign master_r[p]    = mem[rd_ptr];

        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= slave_r;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push)
                    wr_ptr <= (wr_ptr == PTRW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= (rd_ptr == PTRW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                if (push && !pop)
                    cnt <= cnt + 1'b1;
                else if (pop && !push)
                    cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ours_axi4_r_id_demux.sv
// ---------------------------------------------------------------------------
// Bench for ours_axi4_r_id_demux with N_OUTPUT=3 (so sel=3 is illegal),
// WIDTH=16, rlast at bit 0, sel in bits [2:1], BUF_DEPTH=2.
// Reference model: one queue of expected beats per port plus an "open burst"
// record; outputs are compared against it on every falling clk edge.
// ---------------------------------------------------------------------------
module tb_ours_axi4_r_id_demux;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int BD = 2;

    logic                clk;
    logic                rst;
    logic                slave_rvld;
    logic [W-1:0]        slave_r;
    logic                slave_rrdy;
    logic [N-1:0]        master_rvld;
    logic [N-1:0][W-1:0] master_r;
    logic [N-1:0]        master_rrdy;
    logic                err_id_vld;
    logic [15:0]         err_cnt;
    logic                clk_en;
    logic [1:0]          dbg_state;

    ours_axi4_r_id_demux #(
        .N_OUTPUT(N), .WIDTH(W), .RLAST_POSITION(0),
        .ID_LSB(1), .ID_WIDTH(2), .BUF_DEPTH(BD)
    ) u_dut (
        .clk(clk), .rst(rst),
        .slave_rvld(slave_rvld), .slave_r(slave_r), .slave_rrdy(slave_rrdy),
        .master_rvld(master_rvld), .master_r(master_r), .master_rrdy(master_rrdy),
        .err_id_vld(err_id_vld), .err_cnt(err_cnt), .clk_en(clk_en),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters and model state ----------------
    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[N][$];
    bit           m_open;
    bit           m_drop;
    int           m_port;
    logic [15:0]  m_err_cnt;
    bit           m_err_pend;

    int           out_cnt[N];
    int           acc_cnt;
    int           err_pulses;
    logic [W-1:0] obs0_q[$];
    logic [W-1:0] sent_q[$];

    bit           rdy_random;
    logic [N-1:0] rdy_force;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    initial begin
        m_open = 0; m_drop = 0; m_port = 0; m_err_cnt = '0; m_err_pend = 0;
        acc_cnt = 0; err_pulses = 0;
        for (int p = 0; p < N; p++) out_cnt[p] = 0;
        forever begin
            @(negedge clk);
            begin
                logic [1:0]   sel;
                bit           legal;
                bit           rlast;
                bit           e_rrdy;
                logic [N-1:0] e_rvld;
                bit           any_ne;
                sel    = slave_r[2:1];
                legal  = (sel < N);
                rlast  = slave_r[0];
                any_ne = 0;
                for (int p = 0; p < N; p++) begin
                    e_rvld[p] = !rst && (exp_q[p].size() > 0);
                    if (exp_q[p].size() > 0) any_ne = 1;
                end
                if (rst)          e_rrdy = 0;
                else if (!m_open) e_rrdy = legal ? (exp_q[sel].size() < BD) : 1;
                else if (m_drop)  e_rrdy = 1;
                else              e_rrdy = (exp_q[m_port].size() < BD);

                chk("slave_rrdy", 32'(slave_rrdy), 32'(e_rrdy));
                chk("master_rvld", 32'(master_rvld), 32'(e_rvld));
                for (int p = 0; p < N; p++)
                    if (e_rvld[p]) chk($sformatf("master_r[%0d]", p), 32'(master_r[p]), 32'(exp_q[p][0]));
                chk("err_id_vld", 32'(err_id_vld), 32'(m_err_pend));
                chk("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
                chk("clk_en", 32'(clk_en), 32'(rst | slave_rvld | m_open | any_ne));
                chk("dbg_state", 32'(dbg_state), !m_open ? 32'd0 : (m_drop ? 32'd2 : 32'd1));

                // observation counters used by the directed checks
                for (int p = 0; p < N; p++)
                    if (master_rvld[p] && master_rrdy[p]) begin
                        out_cnt[p]++;
                        if (p == 0) obs0_q.push_back(master_r[0]);
                    end
                if (slave_rvld && slave_rrdy) acc_cnt++;
                if (err_id_vld) err_pulses++;

                // advance the model across the coming rising edge
                if (rst) begin
                    for (int p = 0; p < N; p++) exp_q[p].delete();
                    m_open = 0; m_drop = 0; m_err_cnt = '0; m_err_pend = 0;
                end else begin
                    m_err_pend = 0;
                    for (int p = 0; p < N; p++)
                        if (e_rvld[p] && master_rrdy[p]) void'(exp_q[p].pop_front());
                    if (slave_rvld && e_rrdy) begin
                        if (!m_open) begin
                            if (legal) begin
                                exp_q[sel].push_back(slave_r);
                                m_port = int'(sel); m_drop = 0;
                            end else begin
                                m_err_pend = 1;
                                if (m_err_cnt != 16'hFFFF) m_err_cnt++;
                                m_drop = 1;
                            end
                            m_open = !rlast;
                        end else begin
                            if (!m_drop) exp_q[m_port].push_back(slave_r);
                            if (rlast) m_open = 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- downstream ready driver ----------------
    initial begin
        master_rrdy = '1;
        forever begin
            @(posedge clk); #1;
            master_rrdy = rdy_random ? N'($urandom_range(0, 7)) : rdy_force;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_beat(input logic [W-1:0] b);
        bit ok;
        bit acc;
        ok = 0;
        slave_rvld = 1'b1;
        slave_r    = b;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk); acc = slave_rrdy;
            @(posedge clk); #1;
            if (acc) ok = 1;
        end
        slave_rvld = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL beat_timeout: beat %0h got no ready, expected acceptance within 300 cycles", b);
        end
    endtask

    // mid_sel >= 0 forces the sel field of the second beat; otherwise later
    // beats carry a random sel that must be ignored.
    task automatic send_burst(input int sel, input int len, input int mid_sel, input bit gaps);
        logic [W-1:0] b;
        for (int i = 0; i < len; i++) begin
            b = W'($urandom_range(0, 65535));
            if (i == 0)                      b[2:1] = 2'(sel);
            else if (i == 1 && mid_sel >= 0) b[2:1] = 2'(mid_sel);
            b[0] = (i == len - 1);
            sent_q.push_back(b);
            send_beat(b);
            if (gaps) cycles($urandom_range(0, 2));
        end
    endtask

    // ---------------- test sequence ----------------
    int base[N];
    int acc0;

    task automatic snap();
        for (int p = 0; p < N; p++) base[p] = out_cnt[p];
        acc0 = acc_cnt;
    endtask

    initial begin
        rst = 1'b1; slave_rvld = 1'b0; slave_r = '0;
        rdy_random = 0; rdy_force = '1;
        cycles(3);
        rst = 1'b0;
        cycles(1); #1;
        chk("reset_rvld", 32'(master_rvld), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        chk("reset_clk_en", 32'(clk_en), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'd0);

        // 4-beat burst to port 2
        snap();
        send_burst(2, 4, -1, 0);
        #1 chk("burst2_state_idle", 32'(dbg_state), 32'd0);
        cycles(4);
        chk("burst2_port2", 32'(out_cnt[2] - base[2]), 32'd4);
        chk("burst2_port0", 32'(out_cnt[0] - base[0] + out_cnt[1] - base[1]), 32'd0);

        // mid-burst sel change: all beats stay on port 1
        snap();
        send_burst(1, 4, 3, 0);
        cycles(4);
        chk("midsel_port1", 32'(out_cnt[1] - base[1]), 32'd4);
        chk("midsel_others", 32'(out_cnt[0] - base[0] + out_cnt[2] - base[2]), 32'd0);
        chk("midsel_err", 32'(err_cnt), 32'd0);

        // back-pressure on port 0
        rdy_force = 3'b110;
        cycles(1);
        snap();
        sent_q.delete(); obs0_q.delete();
        fork
            send_burst(0, 5, -1, 0);
        join_none
        cycles(10); #1;
        chk("bp_accepted", 32'(acc_cnt - acc0), 32'd2);
        chk("bp_rrdy_low", 32'(slave_rrdy), 32'd0);
        chk("bp_no_out", 32'(out_cnt[0] - base[0]), 32'd0);
        rdy_force = 3'b111;
        wait fork;
        cycles(5);
        chk("bp_drained", 32'(obs0_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs0_q.size(); i++)
            chk($sformatf("bp_order[%0d]", i), 32'(obs0_q[i]), 32'(sent_q[i]));

        // illegal ID burst, then a normal one
        snap();
        err_pulses = 0;
        send_burst(3, 3, -1, 0);
        cycles(2);
        chk("ill_accepted", 32'(acc_cnt - acc0), 32'd3);
        chk("ill_err_cnt", 32'(err_cnt), 32'd1);
        chk("ill_pulses", 32'(err_pulses), 32'd1);
        chk("ill_no_out", 32'(out_cnt[0] - base[0] + out_cnt[1] - base[1] + out_cnt[2] - base[2]), 32'd0);
        send_burst(0, 2, -1, 0);
        cycles(3);
        chk("after_ill_port0", 32'(out_cnt[0] - base[0]), 32'd2);

        // reset in the middle of a burst to port 1
        rdy_force = 3'b101;
        cycles(1);
        send_beat(16'h5a02);
        send_beat(16'ha5b2);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        rdy_force = 3'b111;
        cycles(1); #1;
        chk("rstmid_rvld", 32'(master_rvld), 32'd0);
        chk("rstmid_state", 32'(dbg_state), 32'd0);
        chk("rstmid_clk_en", 32'(clk_en), 32'd0);
        chk("rstmid_err_cnt", 32'(err_cnt), 32'd0);
        snap();
        send_burst(0, 3, -1, 0);
        cycles(4);
        chk("rstmid_port0", 32'(out_cnt[0] - base[0]), 32'd3);
        chk("rstmid_port1", 32'(out_cnt[1] - base[1]), 32'd0);

        // randomized traffic with random downstream stalls
        rdy_random = 1;
        for (int k = 0; k < 120; k++)
            send_burst($urandom_range(0, 3), $urandom_range(1, 5), -1, 1);
        rdy_random = 0;
        rdy_force = '1;
        cycles(10); #1;
        chk("final_empty", 32'(master_rvld), 32'd0);
        chk("final_idle", 32'(dbg_state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
